// File: rtl/mux_scan_n.sv
// N-channel, W-bit registered multiplexer with manual channel select and a
// round-robin auto-scan mode that holds each channel for a programmable dwell.
module mux_scan_n #(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 1,
  parameter int DWELL_W = 8,
  parameter int SEL_W   = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH*DATA_W-1:0] D_in,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       select,
  input  logic [DWELL_W-1:0]     dwell,
  input  logic                   enable,
  output logic [DATA_W-1:0]      D_out,
  output logic                   D_valid,
  output logic [SEL_W-1:0]       cur_sel,
  output logic                   wrap,
  output logic                   dbg_state
);

  // Handshake: D_valid is high for exactly the cycles in which D_out was
  // reloaded (the cycle after an enabled edge); there is no backpressure.

  typedef enum logic {S_MANUAL = 1'b0, S_SCAN = 1'b1} state_t;

  localparam logic [SEL_W:0]   N_CH_L  = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [SEL_W-1:0]   man_ch;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               wrap_d;
  logic [DATA_W-1:0]  sel_data;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    // Out-of-range manual selects fall back to channel 0.
    man_ch  = ({1'b0, select} < N_CH_L) ? select : '0;
    case (state_q)
      S_MANUAL: begin
        if (mode) begin
          state_d = S_SCAN;
          ch_d    = '0;
          cnt_d   = '0;
        end else begin
          ch_d = man_ch;
        end
      end
      S_SCAN: begin
        if (!mode) begin
          state_d = S_MANUAL;
          ch_d    = man_ch;
          cnt_d   = '0;
        end else if (cnt_q >= dwell) begin
          // >= rather than == so a dwell lowered mid-hold advances at once.
          cnt_d = '0;
          if (ch_q == LAST_CH) begin
            ch_d   = '0;
            wrap_d = 1'b1;
          end else begin
            ch_d = ch_q + SEL_W'(1);
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: state_d = S_MANUAL;
    endcase

    sel_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (SEL_W'(k) == ch_d) sel_data = D_in[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_MANUAL;
      ch_q    <= '0;
      cnt_q   <= '0;
      D_out   <= '0;
      D_valid <= 1'b0;
      wrap    <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      D_out   <= sel_data;
      D_valid <= 1'b1;
      wrap    <= wrap_d;
    end else begin
      D_valid <= 1'b0;
      wrap    <= 1'b0;
    end
  end

  assign cur_sel   = ch_q;
  assign dbg_state = state_q;

endmodule
